// File: rtl/mem_read_arbiter_pkg.sv
// Shared encodings for the I/D cache read-miss arbiter: FSM states and requester ids.
package mem_read_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ADDR  = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic ID_I = 1'b0;
    localparam logic ID_D = 1'b1;

endpackage

// File: rtl/mem_read_arbiter_rr_pick.sv
// Two-way requester pick with a priority pointer; only built when ARB_ROUND_ROBIN_EN is defined.
`ifdef ARB_ROUND_ROBIN_EN
module arb_rr_pick
    import mem_read_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic ptr,
    output logic pick_c,
    output logic valid_c
);

    assign valid_c = req_i | req_d;

    // Pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        pick_c = ID_D;
        if (req_i && req_d) begin
            pick_c = ptr;
        end else if (req_i) begin
            pick_c = ID_I;
        end
    end

endmodule
`endif

// File: rtl/mem_read_arbiter.sv
// Arbitrates I-cache and D-cache read misses onto one AXI-style read channel, one burst at a time.
// ARB_ROUND_ROBIN_EN: alternate the winner on ties instead of fixed D-over-I priority.
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [LEN_W-1:0]  ic_len,
    input  logic              ic_cancel,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic              ic_rlast,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LEN_W-1:0]  dc_len,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic              dc_rlast,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              ar_valid,
    output logic [ADDR_W-1:0] ar_addr,
    output logic [LEN_W-1:0]  ar_len,
    output logic              ar_id,
    input  logic              ar_ready,
    input  logic              r_valid,
    input  logic [DATA_W-1:0] r_data,
    input  logic              r_last,
    input  logic              r_id,
    output logic              r_ready
);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              id_q, id_d;
    logic              cxl_q, cxl_d;
    logic              ic_ok_c, any_req_c, win_id_c;
    logic              cancel_c, beat_ok_c, fwd_c;

    assign ic_ok_c   = ic_req & ~ic_cancel;
    assign cancel_c  = (id_q == ID_I) & (ic_cancel | cxl_q);
    assign beat_ok_c = r_valid & (r_id == id_q);

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    arb_rr_pick u_pick (
        .req_i  (ic_ok_c),
        .req_d  (dc_req),
        .ptr    (ptr_q),
        .pick_c (win_id_c),
        .valid_c(any_req_c)
    );

    // Hand priority to the other requester once a burst finishes or drains.
    always_comb begin
        ptr_d = ptr_q;
        if (state_d == ST_IDLE && (state_q == ST_DATA || state_q == ST_DRAIN)) begin
            ptr_d = ~id_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q <= ID_D;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign any_req_c = ic_ok_c | dc_req;
    assign win_id_c  = dc_req ? ID_D : ID_I;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            id_q    <= ID_I;
            cxl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            id_q    <= id_d;
            cxl_q   <= cxl_d;
        end
    end

    // cxl_q remembers an I flush seen while the address is still waiting for ar_ready.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        id_d     = id_q;
        cxl_d    = cxl_q;
        ar_valid = 1'b0;
        r_ready  = 1'b0;
        ic_gnt   = 1'b0;
        dc_gnt   = 1'b0;
        fwd_c    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cxl_d = 1'b0;
                if (any_req_c) begin
                    id_d    = win_id_c;
                    addr_d  = (win_id_c == ID_D) ? dc_addr : ic_addr;
                    len_d   = (win_id_c == ID_D) ? dc_len : ic_len;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                ar_valid = 1'b1;
                if (id_q == ID_I && ic_cancel) begin
                    cxl_d = 1'b1;
                end
                if (ar_ready) begin
                    if (cancel_c) begin
                        state_d = ST_DRAIN;
                    end else begin
                        ic_gnt  = (id_q == ID_I);
                        dc_gnt  = (id_q == ID_D);
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                r_ready = 1'b1;
                fwd_c   = beat_ok_c & ~cancel_c;
                if (beat_ok_c && r_last) begin
                    state_d = ST_IDLE;
                end else if (cancel_c) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                r_ready = 1'b1;
                if (r_valid && r_last) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign ic_rvalid = fwd_c & (id_q == ID_I);
    assign dc_rvalid = fwd_c & (id_q == ID_D);
    assign ic_rlast  = ic_rvalid & r_last;
    assign dc_rlast  = dc_rvalid & r_last;
    assign ic_rdata  = ic_rvalid ? r_data : '0;
    assign dc_rdata  = dc_rvalid ? r_data : '0;

    assign ar_addr = addr_q;
    assign ar_len  = len_q;
    assign ar_id   = id_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: expected beats queued as driven, popped as forwarded.
module tb_mem_read_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LEN_W  = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              ic_req = 1'b0, dc_req = 1'b0, ic_cancel = 1'b0;
    logic [ADDR_W-1:0] ic_addr = '0, dc_addr = '0;
    logic [LEN_W-1:0]  ic_len = '0, dc_len = '0;
    logic              ic_gnt, ic_rvalid, ic_rlast, dc_gnt, dc_rvalid, dc_rlast;
    logic [DATA_W-1:0] ic_rdata, dc_rdata;
    logic              ar_valid, ar_id, r_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_len;
    logic              ar_ready = 1'b0, r_valid = 1'b0, r_last = 1'b0, r_id = 1'b0;
    logic [DATA_W-1:0] r_data = '0;

    typedef struct packed {
        logic              owner;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t sb[$];
    int    errors = 0;
    int    checks = 0;
    int    ic_gnt_cnt = 0;
    int    dc_gnt_cnt = 0;
    logic  rr_next = 1'b1;

    mem_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .resetn(resetn),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_len(ic_len), .ic_cancel(ic_cancel),
        .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast), .ic_rdata(ic_rdata),
        .dc_req(dc_req), .dc_addr(dc_addr), .dc_len(dc_len),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast), .dc_rdata(dc_rdata),
        .ar_valid(ar_valid), .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
        .ar_ready(ar_ready),
        .r_valid(r_valid), .r_data(r_data), .r_last(r_last), .r_id(r_id), .r_ready(r_ready)
    );

    always #5 clk = ~clk;

    // Grant exclusivity and forwarded beats against the scoreboard.
    always @(negedge clk) begin
        beat_t exp;
        if (ic_gnt === 1'b1 || dc_gnt === 1'b1) begin
            checks++;
            if (ic_gnt === 1'b1 && dc_gnt === 1'b1) begin
                errors++;
                $display("FAIL gnt_excl: both grants high at %0t", $time);
            end
            if (ic_gnt === 1'b1) ic_gnt_cnt++;
            if (dc_gnt === 1'b1) dc_gnt_cnt++;
        end
        if (ic_rvalid === 1'b1 || dc_rvalid === 1'b1) begin
            checks++;
            if (ic_rvalid === 1'b1 && dc_rvalid === 1'b1) begin
                errors++;
                $display("FAIL rvalid_excl: both rvalid high at %0t", $time);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: ic_rvalid=%b dc_rvalid=%b data=%h, none expected at %0t",
                         ic_rvalid, dc_rvalid, dc_rvalid ? dc_rdata : ic_rdata, $time);
            end else begin
                exp = sb.pop_front();
                if (dc_rvalid !== exp.owner
                    || (dc_rvalid ? dc_rdata : ic_rdata) !== exp.data
                    || (dc_rvalid ? dc_rlast : ic_rlast) !== exp.last) begin
                    errors++;
                    $display("FAIL beat: got owner=%b data=%h last=%b, want owner=%b data=%h last=%b",
                             dc_rvalid, dc_rvalid ? dc_rdata : ic_rdata,
                             dc_rvalid ? dc_rlast : ic_rlast, exp.owner, exp.data, exp.last);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic note_done(input logic owner);
        rr_next = ~owner;
    endtask

    function automatic logic exp_winner();
        return RR ? rr_next : 1'b1;
    endfunction

    task automatic wait_addr(output int n);
        bit ok = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (ar_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ar_valid_timeout: ar_valid=%b after %0d cycles, want 1", ar_valid, n);
        end
    endtask

    // Address phase: optional ar_ready delay and an I flush injected at a given wait cycle.
    task automatic handshake(input logic id, input logic [ADDR_W-1:0] addr,
                             input logic [LEN_W-1:0] len, input int delay,
                             input bit exp_gnt, input int cancel_at, output int n);
        wait_addr(n);
        checks++;
        if (ar_id !== id || ar_addr !== addr || ar_len !== len) begin
            errors++;
            $display("FAIL ar_fields: id=%b addr=%h len=%0d, want id=%b addr=%h len=%0d",
                     ar_id, ar_addr, ar_len, id, addr, len);
        end
        for (int i = 0; i < delay; i++) begin
            tick();
            if (i == cancel_at) begin
                ic_cancel = 1'b1;
                ic_req    = 1'b0;
            end else begin
                ic_cancel = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (ar_valid !== 1'b1 || ic_gnt !== 1'b0 || dc_gnt !== 1'b0) begin
                errors++;
                $display("FAIL ar_hold: ar_valid=%b ic_gnt=%b dc_gnt=%b, want 1 0 0",
                         ar_valid, ic_gnt, dc_gnt);
            end
        end
        tick();
        ic_cancel = 1'b0;
        ar_ready  = 1'b1;
        @(negedge clk);
        checks++;
        if (ic_gnt !== (exp_gnt && id == 1'b0) || dc_gnt !== (exp_gnt && id == 1'b1)) begin
            errors++;
            $display("FAIL gnt: ic_gnt=%b dc_gnt=%b, want %b %b", ic_gnt, dc_gnt,
                     exp_gnt && id == 1'b0, exp_gnt && id == 1'b1);
        end
        tick();
        ar_ready = 1'b0;
        if (exp_gnt) begin
            if (id) dc_req = 1'b0;
            else    ic_req = 1'b0;
        end
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic rid, input logic last,
                        input bit fwd, input logic owner);
        r_valid = 1'b1;
        r_data  = d;
        r_id    = rid;
        r_last  = last;
        if (fwd) sb.push_back('{owner: owner, data: d, last: last});
        @(negedge clk);
        checks++;
        if (r_ready !== 1'b1) begin
            errors++;
            $display("FAIL r_ready: got %b want 1 during beat %h", r_ready, d);
        end
        tick();
        r_valid = 1'b0;
        r_last  = 1'b0;
    endtask

    task automatic end_check(input string name);
        @(negedge clk);
        checks++;
        if (ar_valid !== 1'b0 || r_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: ar_valid=%b r_ready=%b, want 0 0", name, ar_valid, r_ready);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d expected beats not forwarded, want 0", name, sb.size());
        end
        sb.delete();
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({ar_valid, r_ready, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast} !== 8'h00
            || ar_addr !== '0 || ar_len !== '0 || ar_id !== 1'b0) begin
            errors++;
            $display("FAIL reset: ctl=%b addr=%h len=%0d id=%b, want all zero",
                     {ar_valid, r_ready, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast},
                     ar_addr, ar_len, ar_id);
        end
        tick();
        resetn = 1'b1;
        rr_next = 1'b1;
        tick();
    endtask

    task automatic test_single_ifetch();
        int n;
        int g0 = ic_gnt_cnt;
        ic_addr = 32'h1FC0_0000;
        ic_len  = 8'd7;
        ic_req  = 1'b1;
        handshake(1'b0, 32'h1FC0_0000, 8'd7, 2, 1'b1, -1, n);
        for (int k = 0; k < 8; k++) beat(32'hA000_0000 + k, 1'b0, k == 7, 1'b1, 1'b0);
        note_done(1'b0);
        end_check("single");
        checks++;
        if (ic_gnt_cnt - g0 != 1) begin
            errors++;
            $display("FAIL single_gnt_count: got %0d ic_gnt pulses want 1", ic_gnt_cnt - g0);
        end
    endtask

    task automatic test_cancel_idle();
        int n;
        ic_addr   = 32'h0000_4000;
        ic_req    = 1'b1;
        ic_cancel = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if (ar_valid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_idle: ar_valid=%b want 0 while I cancelled", ar_valid);
        end
        tick();
        dc_addr = 32'h8000_0040;
        dc_len  = 8'd1;
        dc_req  = 1'b1;
        handshake(1'b1, 32'h8000_0040, 8'd1, 0, 1'b1, -1, n);
        ic_req    = 1'b0;
        ic_cancel = 1'b1;
        beat(32'hD000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        beat(32'hD000_0001, 1'b1, 1'b1, 1'b1, 1'b1);
        ic_cancel = 1'b0;
        note_done(1'b1);
        end_check("cancel_idle");
    endtask

    task automatic test_pair();
        int n;
        logic w = exp_winner();
        ic_addr = 32'h0000_1000;
        ic_len  = 8'd3;
        dc_addr = 32'h8000_2000;
        dc_len  = 8'd3;
        ic_req  = 1'b1;
        dc_req  = 1'b1;
        handshake(w, w ? 32'h8000_2000 : 32'h0000_1000, 8'd3, 0, 1'b1, -1, n);
        for (int k = 0; k < 4; k++) beat(32'hB000_0000 + k, w, k == 3, 1'b1, w);
        note_done(w);
        end_check("pair_first");
        handshake(~w, w ? 32'h0000_1000 : 32'h8000_2000, 8'd3, 0, 1'b1, -1, n);
        checks++;
        if (n != 1) begin
            errors++;
            $display("FAIL pair_bubble: loser address after %0d cycles want 1", n);
        end
        for (int k = 0; k < 4; k++) beat(32'hC000_0000 + k, ~w, k == 3, 1'b1, ~w);
        note_done(~w);
        end_check("pair_second");
    endtask

    task automatic test_cancel_data();
        int n;
        ic_addr = 32'h0000_2000;
        ic_len  = 8'd7;
        ic_req  = 1'b1;
        handshake(1'b0, 32'h0000_2000, 8'd7, 0, 1'b1, -1, n);
        for (int k = 0; k < 8; k++) begin
            ic_cancel = (k == 2);
            beat(32'hE000_0000 + k, 1'b0, k == 7, k < 2, 1'b0);
        end
        ic_cancel = 1'b0;
        note_done(1'b0);
        end_check("cancel_data");
    endtask

    task automatic test_cancel_addr();
        int n;
        int g0 = ic_gnt_cnt;
        ic_addr = 32'h0000_3000;
        ic_len  = 8'd3;
        ic_req  = 1'b1;
        handshake(1'b0, 32'h0000_3000, 8'd3, 4, 1'b0, 0, n);
        for (int k = 0; k < 4; k++) beat(32'hF000_0000 + k, 1'b0, k == 3, 1'b0, 1'b0);
        note_done(1'b0);
        end_check("cancel_addr");
        checks++;
        if (ic_gnt_cnt != g0) begin
            errors++;
            $display("FAIL cancel_addr_gnt: got %0d ic_gnt pulses want 0", ic_gnt_cnt - g0);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        dc_addr = 32'h8000_1000;
        dc_len  = 8'd7;
        dc_req  = 1'b1;
        handshake(1'b1, 32'h8000_1000, 8'd7, 1, 1'b1, -1, n);
        for (int k = 0; k < 3; k++) beat(32'h9000_0000 + k, 1'b1, 1'b0, 1'b1, 1'b1);
        r_valid = 1'b1;
        r_data  = 32'h9000_0003;
        r_id    = 1'b1;
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({ar_valid, r_ready, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast} !== 8'h00
            || ar_addr !== '0 || ar_len !== '0 || ar_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ctl=%b addr=%h len=%0d id=%b, want all zero",
                     {ar_valid, r_ready, ic_gnt, dc_gnt, ic_rvalid, dc_rvalid, ic_rlast, dc_rlast},
                     ar_addr, ar_len, ar_id);
        end
        rr_next = 1'b1;
        tick();
        r_data = 32'h9000_0004;
        tick();
        resetn = 1'b1;
        r_data = 32'h9000_0005;
        @(negedge clk);
        checks++;
        if (r_ready !== 1'b0 || dc_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_stray: r_ready=%b dc_rvalid=%b, want 0 0", r_ready, dc_rvalid);
        end
        tick();
        r_valid = 1'b0;
        dc_addr = 32'h8000_3000;
        dc_len  = 8'd0;
        dc_req  = 1'b1;
        handshake(1'b1, 32'h8000_3000, 8'd0, 0, 1'b1, -1, n);
        beat(32'h9100_0000, 1'b1, 1'b1, 1'b1, 1'b1);
        note_done(1'b1);
        end_check("reset_mid");
    endtask

    task automatic test_rid_mismatch();
        int n;
        dc_addr = 32'h8000_4000;
        dc_len  = 8'd3;
        dc_req  = 1'b1;
        handshake(1'b1, 32'h8000_4000, 8'd3, 0, 1'b1, -1, n);
        beat(32'h7000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
        beat(32'h7000_0BAD, 1'b0, 1'b0, 1'b0, 1'b1);
        ic_cancel = 1'b1;
        beat(32'h7000_0001, 1'b1, 1'b0, 1'b1, 1'b1);
        ic_cancel = 1'b0;
        beat(32'h7000_0002, 1'b1, 1'b1, 1'b1, 1'b1);
        note_done(1'b1);
        end_check("rid_mismatch");
    endtask

    initial begin
        test_reset();
        test_single_ifetch();
        test_cancel_idle();
        test_pair();
        test_pair();
        test_cancel_data();
        test_cancel_addr();
        test_reset_mid();
        test_rid_mismatch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, request/bus address width.
REQ-002 Parameter: DATA_W, 32, read data width.
REQ-003 Parameter: LEN_W, 8, burst length field width (beats minus one).
REQ-004 Port: clk  in  1  sole clock; all logic on rising edge.
REQ-005 Port: resetn  in  1  asynchronous, active-low reset.
REQ-006 Ports: ic_req/dc_req  in  1  cache miss read request, held until granted.
REQ-007 Ports: ic_addr/dc_addr  in  ADDR_W; ic_len/dc_len  in  LEN_W  request address and length.
REQ-008 Ports: ic_gnt/dc_gnt  out  1  one-cycle pulse: request accepted by bus (AR handshake).
REQ-009 Ports: ic_rvalid/dc_rvalid  out  1; ic_rlast/dc_rlast  out  1; ic_rdata/dc_rdata  out  DATA_W  returned beats.
REQ-010 Port: ic_cancel  in  1  exception/refetch flush of the pending i-fetch.
REQ-011 Ports: ar_valid out 1, ar_addr out ADDR_W, ar_len out LEN_W, ar_id out 1 (0=I, 1=D), ar_ready in 1.
REQ-012 Ports: r_valid in 1, r_data in DATA_W, r_last in 1, r_id in 1, r_ready out 1.

Function
REQ-013 FSM states IDLE, ADDR, DATA, DRAIN; exactly one transaction outstanding at a time.
REQ-014 IDLE: on any request, latch winner's addr/len/id, go ADDR next cycle; no request -> stay.
REQ-015 Arbitration without macro: dc_req wins over ic_req when both asserted.
REQ-016 ADDR: ar_valid=1 with latched fields stable; on ar_ready pulse winner's gnt same cycle, go DATA.
REQ-017 DATA: r_ready=1; each r_valid beat routed combinationally (zero latency) to owner's rvalid/rdata/rlast; other side's rvalid=0.
REQ-018 DATA: r_valid&r_last -> IDLE; new arbitration possible the cycle after (one idle bubble minimum).
REQ-019 r_id mismatching latched id -> beat consumed, not forwarded; no state change.
REQ-020 ic_cancel in IDLE or with ic not granted -> nothing latched for I that cycle; dc_req still arbitrated.
REQ-021 ic_cancel in ADDR owned by I: ar_valid held until handshake (AXI rule), no ic_gnt, then DRAIN.
REQ-022 ic_cancel in DATA owned by I (incl. last-beat cycle): no further ic_rvalid from that cycle; DRAIN unless that beat is last -> IDLE.
REQ-023 DRAIN: r_ready=1, beats discarded, ic_rvalid=0; r_last -> IDLE.
REQ-024 ic_cancel ignored when D owns the transaction.
REQ-025 gnt and rvalid never asserted for both requesters in same cycle.

Reset
REQ-026 resetn low -> IDLE immediately; ar_valid, r_ready, all gnt/rvalid/rlast 0; latched addr/len/id 0; priority pointer selects D.
REQ-027 Reset mid-burst abandons transaction; no beat forwarded after reset deassertion until a new grant.

Configuration
REQ-028 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, winner alternates; pointer flips to other requester after each completed or drained transaction.
REQ-029 Macro undefined: fixed D-over-I priority per REQ-015; pointer logic absent.

Structure
REQ-030 Shared package: FSM state encoding, requester id constants (ID_I=0, ID_D=1).
REQ-031 One sub-module natural: arb_rr_pick (2-way pick with pointer), instantiated only under ARB_ROUND_ROBIN_EN.

Verification
REQ-032 ic_req alone addr 0x1FC00000 len 7, ar_ready after 2 cycles -> one ic_gnt pulse, 8 ic_rvalid beats, ic_rlast on 8th, return to IDLE.
REQ-033 ic_req and dc_req same cycle, no macro -> D granted first, I after D's r_last plus one cycle; with macro, second simultaneous pair grants I first.
REQ-034 ic_cancel on 3rd beat of 8-beat I burst -> beats 3-8 discarded, r_ready stays 1, no ic_rlast, IDLE after r_last.
REQ-035 ic_cancel while ar_valid=1, ar_ready withheld 4 cycles -> ar_valid stays high, no ic_gnt, DRAIN consumes all beats.
REQ-036 resetn low during beat 4 of D burst -> all outputs 0 asynchronously, next dc_req gets fresh ADDR phase.
REQ-037 Beat with r_id=0 while D owns -> no dc_rvalid, no ic_rvalid, burst continues.
